icap_seq_ctrl: RTL and testbench

ICAP_SEQ_CTRL -- requirements
Module: icap_seq_ctrl

---
 rtl/icap_seq_ctrl_pkg.sv | 84 ++++++++
 rtl/icap_bitswap.sv | 16 +
 rtl/icap_seq_ctrl.sv | 199 +++++++++++++++++++
 tb/tb_icap_seq_ctrl.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/icap_seq_ctrl_pkg.sv
// Shared ICAP command words, sequence indices, the controller state enum
// and the word-list lookups used by the sequencer.
package icap_seq_ctrl_pkg;

    localparam int unsigned WORD_W = 16;
    localparam int unsigned IDX_W  = 4;
    localparam int unsigned ADDR_W = 24;

    // ICAP word constants (16-bit configuration interface)
    localparam logic [WORD_W-1:0] W_DUMMY       = 16'hFFFF;
    localparam logic [WORD_W-1:0] W_SYNC0       = 16'hAA99;
    localparam logic [WORD_W-1:0] W_SYNC1       = 16'h5566;
    localparam logic [WORD_W-1:0] W_NOOP        = 16'h2000;
    localparam logic [WORD_W-1:0] W_HDR_GEN1    = 16'h3261;
    localparam logic [WORD_W-1:0] W_HDR_GEN2    = 16'h3281;
    localparam logic [WORD_W-1:0] W_HDR_GEN3    = 16'h32A1;
    localparam logic [WORD_W-1:0] W_HDR_GEN4    = 16'h32C1;
    localparam logic [WORD_W-1:0] W_HDR_CMD     = 16'h30A1;
    localparam logic [WORD_W-1:0] W_HDR_RD_STAT = 16'h2901;
    localparam logic [WORD_W-1:0] W_CMD_IPROG   = 16'h000E;
    localparam logic [WORD_W-1:0] W_CMD_DESYNC  = 16'h000D;

    // Last index of each word list and the IPROG word position
    localparam logic [IDX_W-1:0] BOOT_LAST    = 4'd15;
    localparam logic [IDX_W-1:0] BOOT_IPROG   = 4'd13;
    localparam logic [IDX_W-1:0] STAT_LAST    = 4'd6;
    localparam logic [IDX_W-1:0] DESYNC_LAST  = 4'd3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_BOOT_WR,
        ST_BOOT_HALT,
        ST_STAT_WR,
        ST_STAT_TURN,
        ST_STAT_RD,
        ST_STAT_DESYNC
    } state_e;

    // IPROG warm-boot word list
    function automatic logic [WORD_W-1:0] boot_word(
        input logic [IDX_W-1:0]  idx,
        input logic [ADDR_W-1:0] addr,
        input logic [7:0]        opcode,
        input logic [ADDR_W-1:0] fb_addr
    );
        case (idx)
            4'd0, 4'd1: boot_word = W_DUMMY;
            4'd2:       boot_word = W_SYNC0;
            4'd3:       boot_word = W_SYNC1;
            4'd4:       boot_word = W_HDR_GEN1;
            4'd5:       boot_word = addr[15:0];
            4'd6:       boot_word = W_HDR_GEN2;
            4'd7:       boot_word = {opcode, addr[23:16]};
            4'd8:       boot_word = W_HDR_GEN3;
            4'd9:       boot_word = fb_addr[15:0];
            4'd10:      boot_word = W_HDR_GEN4;
            4'd11:      boot_word = {opcode, fb_addr[23:16]};
            4'd12:      boot_word = W_HDR_CMD;
            4'd13:      boot_word = W_CMD_IPROG;
            default:    boot_word = W_NOOP;
        endcase
    endfunction

    // STAT read request word list
    function automatic logic [WORD_W-1:0] stat_word(input logic [IDX_W-1:0] idx);
        case (idx)
            4'd0:       stat_word = W_DUMMY;
            4'd1:       stat_word = W_SYNC0;
            4'd2:       stat_word = W_SYNC1;
            4'd4:       stat_word = W_HDR_RD_STAT;
            default:    stat_word = W_NOOP;
        endcase
    endfunction

    // DESYNC word list closing a STAT read
    function automatic logic [WORD_W-1:0] desync_word(input logic [IDX_W-1:0] idx);
        case (idx)
            4'd0:       desync_word = W_HDR_CMD;
            4'd1:       desync_word = W_CMD_DESYNC;
            default:    desync_word = W_NOOP;
        endcase
    endfunction

endpackage

// File: rtl/icap_bitswap.sv
// Reverses bit order within each byte of a 16-bit ICAP word.
//   d_i : word in natural bit order
//   q_o : word with each byte bit-reversed
module icap_bitswap
    import icap_seq_ctrl_pkg::*;
(
    input  logic [WORD_W-1:0] d_i,
    output logic [WORD_W-1:0] q_o
);

    for (genvar i = 0; i < 8; i++) begin : g_swap
        assign q_o[i]     = d_i[7-i];
        assign q_o[8+i]   = d_i[15-i];
    end

endmodule

// File: rtl/icap_seq_ctrl.sv
// ICAP sequencer: issues IPROG warm-boot and STAT register read sequences.
//   clk, rst_n           : clock, async active-low reset
//   boot_req/boot_addr   : warm-boot request and target address; boot_ack pulse
//   stat_req             : STAT read request; stat_valid/stat_data/stat_err result
//   busy                 : high whenever a sequence is active
//   icap_ce_n/icap_wr_n  : ICAP strobes (active-low); icap_din/icap_dout data
//   icap_busy            : ICAP busy flag, stalls words and reads
module icap_seq_ctrl
    import icap_seq_ctrl_pkg::*;
#(
    parameter logic [7:0]        SPI_OPCODE    = 8'h0B,
    parameter logic [ADDR_W-1:0] FALLBACK_ADDR = 24'h000000,
    parameter int unsigned       RD_TIMEOUT    = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              boot_req,
    input  logic [ADDR_W-1:0] boot_addr,
    output logic              boot_ack,
    input  logic              stat_req,
    output logic              stat_valid,
    output logic [WORD_W-1:0] stat_data,
    output logic              stat_err,
    output logic              busy,
    output logic              icap_ce_n,
    output logic              icap_wr_n,
    output logic [WORD_W-1:0] icap_din,
    input  logic [WORD_W-1:0] icap_dout,
    input  logic              icap_busy
);

    localparam int unsigned TMO_W = $clog2(RD_TIMEOUT + 1);

    state_e              state_q, state_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [TMO_W-1:0]    tmo_q, tmo_d;
    logic                rd_done_q, rd_done_d;
    logic                boot_ack_q, boot_ack_d;
    logic                stat_valid_q, stat_valid_d;
    logic [WORD_W-1:0]   stat_data_q, stat_data_d;
    logic                stat_err_q, stat_err_d;
    logic                busy_q, busy_d;
    logic                ce_n_q, ce_n_d;
    logic                wr_n_q, wr_n_d;
    logic [WORD_W-1:0]   din_q, din_d;
    logic [WORD_W-1:0]   dout_sw;

    icap_bitswap u_swap_din  (.d_i(din_q),     .q_o(icap_din));
    icap_bitswap u_swap_dout (.d_i(icap_dout), .q_o(dout_sw));

    // Next-state, sequencing and output decode
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        addr_d       = addr_q;
        tmo_d        = tmo_q;
        rd_done_d    = rd_done_q;
        stat_data_d  = stat_data_q;
        stat_err_d   = stat_err_q;
        boot_ack_d   = 1'b0;
        stat_valid_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (boot_req) begin
                    state_d = ST_BOOT_WR;
                    idx_d   = '0;
                    addr_d  = boot_addr;
                end else if (stat_req) begin
                    state_d = ST_STAT_WR;
                    idx_d   = '0;
                    addr_d  = boot_addr;
                end
            end
            ST_BOOT_WR: begin
                if (!icap_busy) begin
                    boot_ack_d = (idx_q == BOOT_IPROG);
                    if (idx_q == BOOT_LAST) state_d = ST_BOOT_HALT;
                    else                    idx_d   = idx_q + 4'd1;
                end
            end
            ST_BOOT_HALT: state_d = ST_BOOT_HALT;
            ST_STAT_WR: begin
                if (!icap_busy) begin
                    if (idx_q == STAT_LAST) begin
                        state_d   = ST_STAT_TURN;
                        rd_done_d = 1'b0;
                    end else begin
                        idx_d = idx_q + 4'd1;
                    end
                end
            end
            // Shared CE-high turnaround: before the read, or before DESYNC
            ST_STAT_TURN: begin
                if (rd_done_q) begin
                    state_d = ST_STAT_DESYNC;
                    idx_d   = '0;
                end else begin
                    state_d = ST_STAT_RD;
                    tmo_d   = '0;
                end
            end
            ST_STAT_RD: begin
                if (!icap_busy) begin
                    stat_data_d = dout_sw;
                    stat_err_d  = 1'b0;
                    state_d     = ST_STAT_TURN;
                    rd_done_d   = 1'b1;
                end else if (tmo_q == TMO_W'(RD_TIMEOUT - 1)) begin
                    stat_data_d = '0;
                    stat_err_d  = 1'b1;
                    state_d     = ST_STAT_TURN;
                    rd_done_d   = 1'b1;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            ST_STAT_DESYNC: begin
                if (!icap_busy) begin
                    if (idx_q == DESYNC_LAST) begin
                        state_d      = ST_IDLE;
                        stat_valid_d = 1'b1;
                    end else begin
                        idx_d = idx_q + 4'd1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // ICAP strobes and word follow the upcoming state so they are registered
        ce_n_d = 1'b1;
        wr_n_d = 1'b1;
        din_d  = W_DUMMY;
        busy_d = (state_d != ST_IDLE);
        case (state_d)
            ST_BOOT_WR: begin
                ce_n_d = 1'b0;
                wr_n_d = 1'b0;
                din_d  = boot_word(idx_d, addr_d, SPI_OPCODE, FALLBACK_ADDR);
            end
            ST_STAT_WR: begin
                ce_n_d = 1'b0;
                wr_n_d = 1'b0;
                din_d  = stat_word(idx_d);
            end
            ST_STAT_DESYNC: begin
                ce_n_d = 1'b0;
                wr_n_d = 1'b0;
                din_d  = desync_word(idx_d);
            end
            ST_STAT_RD: ce_n_d = 1'b0;
            default: ;
        endcase
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            idx_q        <= '0;
            addr_q       <= '0;
            tmo_q        <= '0;
            rd_done_q    <= 1'b0;
            boot_ack_q   <= 1'b0;
            stat_valid_q <= 1'b0;
            stat_data_q  <= '0;
            stat_err_q   <= 1'b0;
            busy_q       <= 1'b0;
            ce_n_q       <= 1'b1;
            wr_n_q       <= 1'b1;
            din_q        <= W_DUMMY;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            addr_q       <= addr_d;
            tmo_q        <= tmo_d;
            rd_done_q    <= rd_done_d;
            boot_ack_q   <= boot_ack_d;
            stat_valid_q <= stat_valid_d;
            stat_data_q  <= stat_data_d;
            stat_err_q   <= stat_err_d;
            busy_q       <= busy_d;
            ce_n_q       <= ce_n_d;
            wr_n_q       <= wr_n_d;
            din_q        <= din_d;
        end
    end

    assign boot_ack   = boot_ack_q;
    assign stat_valid = stat_valid_q;
    assign stat_data  = stat_data_q;
    assign stat_err   = stat_err_q;
    assign busy       = busy_q;
    assign icap_ce_n  = ce_n_q;
    assign icap_wr_n  = wr_n_q;

endmodule

// File: tb/tb_icap_seq_ctrl.sv
// Self-checking bench for icap_seq_ctrl: directed boot/stat scenarios plus
// randomized addresses, read data and ICAP busy stalls against a word-queue model.
module tb_icap_seq_ctrl;

    localparam int RD_TMO = 255;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        boot_req;
    logic [23:0] boot_addr;
    logic        boot_ack;
    logic        stat_req;
    logic        stat_valid;
    logic [15:0] stat_data;
    logic        stat_err;
    logic        busy;
    logic        icap_ce_n;
    logic        icap_wr_n;
    logic [15:0] icap_din;
    logic [15:0] icap_dout;
    logic        icap_busy;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    icap_seq_ctrl #(
        .SPI_OPCODE   (8'h0B),
        .FALLBACK_ADDR(24'h000000),
        .RD_TIMEOUT   (255)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .boot_req  (boot_req),
        .boot_addr (boot_addr),
        .boot_ack  (boot_ack),
        .stat_req  (stat_req),
        .stat_valid(stat_valid),
        .stat_data (stat_data),
        .stat_err  (stat_err),
        .busy      (busy),
        .icap_ce_n (icap_ce_n),
        .icap_wr_n (icap_wr_n),
        .icap_din  (icap_din),
        .icap_dout (icap_dout),
        .icap_busy (icap_busy)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] bswap(input logic [15:0] w);
        logic [15:0] r;
        for (int i = 0; i < 8; i++) begin
            r[i]   = w[7-i];
            r[8+i] = w[15-i];
        end
        return r;
    endfunction

    function automatic logic [15:0] boot_w(input int k, input logic [23:0] a);
        logic [15:0] t [16];
        t = '{16'hFFFF, 16'hFFFF, 16'hAA99, 16'h5566, 16'h3261, a[15:0], 16'h3281,
              {8'h0B, a[23:16]}, 16'h32A1, 16'h0000, 16'h32C1, 16'h0B00,
              16'h30A1, 16'h000E, 16'h2000, 16'h2000};
        return t[k];
    endfunction

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_ce"},    32'(icap_ce_n), 32'd1);
        chk({tag, "_wr"},    32'(icap_wr_n), 32'd1);
        chk({tag, "_din"},   32'(icap_din), 32'hFFFF);
        chk({tag, "_ack"},   32'(boot_ack), 32'd0);
        chk({tag, "_valid"}, 32'(stat_valid), 32'd0);
        chk({tag, "_err"},   32'(stat_err), 32'd0);
        chk({tag, "_busy"},  32'(busy), 32'd0);
        chk({tag, "_data"},  32'(stat_data), 32'd0);
    endtask

    task automatic do_reset();
        boot_req  = 1'b0;
        stat_req  = 1'b0;
        icap_busy = 1'b0;
        rst_n     = 1'b0;
        #1;
        check_reset_outputs("rst");
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    // Boot sequence: model walks the 16-word list, advancing on busy-free cycles.
    task automatic run_boot(input logic [23:0] addr, input bit rnd, input int stall_k,
                            input int stall_len, input bit with_stat, input int abort_k,
                            output int ack_c);
        int k = 0, c = 0, exp_ack = -1, stall_left = stall_len, drop_c;
        logic b;
        ack_c     = -1;
        drop_c    = rnd ? int'($urandom_range(1, 6)) : 1000;
        boot_addr = addr;
        boot_req  = 1'b1;
        if (with_stat) stat_req = 1'b1;
        icap_busy = 1'b0;
        chk("grant_idle", 32'(busy), 32'd0);
        while (k < 16) begin
            tick();
            c++;
            if (c > 300) begin
                chk("boot_bound", 32'(k), 32'd16);
                break;
            end
            if (c == drop_c) boot_req = 1'b0;
            chk("boot_busy",  32'(busy), 32'd1);
            chk("boot_ce",    32'(icap_ce_n), 32'd0);
            chk("boot_wr",    32'(icap_wr_n), 32'd0);
            chk("boot_din",   32'(icap_din), 32'(bswap(boot_w(k, addr))));
            chk("boot_ack",   32'(boot_ack), 32'(c == exp_ack));
            chk("boot_valid", 32'(stat_valid), 32'd0);
            if (boot_ack) ack_c = c;
            if (k == 7 && addr == 24'h080000) chk("word7", 32'(bswap(icap_din)), 32'h0B08);
            if (k == abort_k) begin
                rst_n = 1'b0;
                #1;
                chk("abort_ce",   32'(icap_ce_n), 32'd1);
                chk("abort_busy", 32'(busy), 32'd0);
                tick();
                chk("abort_ce2",   32'(icap_ce_n), 32'd1);
                chk("abort_busy2", 32'(busy), 32'd0);
                chk("abort_ack",   32'(boot_ack), 32'd0);
                rst_n    = 1'b1;
                boot_req = 1'b0;
                stat_req = 1'b0;
                return;
            end
            if (k == stall_k && stall_left > 0) begin
                b = 1'b1;
                stall_left--;
            end else begin
                b = rnd ? ($urandom_range(0, 3) == 0) : 1'b0;
            end
            icap_busy = b;
            if (!b) begin
                if (k == 13) exp_ack = c + 1;
                k++;
            end
        end
        boot_req = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (i == 1) stat_req = 1'b1;
            tick();
            chk("halt_ce",    32'(icap_ce_n), 32'd1);
            chk("halt_wr",    32'(icap_wr_n), 32'd1);
            chk("halt_busy",  32'(busy), 32'd1);
            chk("halt_ack",   32'(boot_ack), 32'd0);
            chk("halt_valid", 32'(stat_valid), 32'd0);
        end
        stat_req = 1'b0;
    endtask

    // STAT read: ops 0=write word, 1=CE-high turnaround, 2=read; mode 0 no stall,
    // 1 random stalls, 2 busy stuck during the read only.
    task automatic run_stat(input logic [15:0] val, input int mode, output int valid_c);
        int          kind [14];
        logic [15:0] word [14];
        logic [15:0] sw [7];
        logic [15:0] dw [4];
        logic [15:0] exp_data = 16'h0;
        logic        exp_err = 1'b0;
        logic        b;
        int p = 0, c = 0, rd_cnt = 0, drop_c;
        sw = '{16'hFFFF, 16'hAA99, 16'h5566, 16'h2000, 16'h2901, 16'h2000, 16'h2000};
        dw = '{16'h30A1, 16'h000D, 16'h2000, 16'h2000};
        for (int i = 0; i < 7; i++) begin kind[i] = 0; word[i] = sw[i]; end
        kind[7] = 1; word[7] = 16'h0;
        kind[8] = 2; word[8] = 16'h0;
        kind[9] = 1; word[9] = 16'h0;
        for (int i = 0; i < 4; i++) begin kind[10+i] = 0; word[10+i] = dw[i]; end
        valid_c   = -1;
        drop_c    = (mode == 1) ? int'($urandom_range(1, 6)) : 1000;
        stat_req  = 1'b1;
        icap_dout = bswap(val);
        icap_busy = 1'b0;
        chk("sgrant_idle", 32'(busy), 32'd0);
        while (p < 14) begin
            tick();
            c++;
            if (c > RD_TMO + 200) begin
                chk("stat_bound", 32'(p), 32'd14);
                break;
            end
            if (c == drop_c) stat_req = 1'b0;
            chk("stat_busy",  32'(busy), 32'd1);
            chk("stat_valid0", 32'(stat_valid), 32'd0);
            chk("stat_ack",   32'(boot_ack), 32'd0);
            b = 1'b0;
            case (kind[p])
                0: begin
                    chk("swr_ce",  32'(icap_ce_n), 32'd0);
                    chk("swr_wr",  32'(icap_wr_n), 32'd0);
                    chk("swr_din", 32'(icap_din), 32'(bswap(word[p])));
                    if (mode == 1) b = ($urandom_range(0, 2) == 0);
                    if (!b) p++;
                end
                1: begin
                    chk("turn_ce", 32'(icap_ce_n), 32'd1);
                    if (mode == 1) b = $urandom_range(0, 1) == 1;
                    p++;
                end
                default: begin
                    chk("rd_ce", 32'(icap_ce_n), 32'd0);
                    chk("rd_wr", 32'(icap_wr_n), 32'd1);
                    b = (mode == 2) ? 1'b1 : (mode == 1) ? ($urandom_range(0, 2) == 0) : 1'b0;
                    if (!b) begin
                        exp_data = val;
                        exp_err  = 1'b0;
                        p++;
                    end else begin
                        rd_cnt++;
                        if (rd_cnt == RD_TMO) begin
                            exp_data = 16'h0;
                            exp_err  = 1'b1;
                            p++;
                        end
                    end
                end
            endcase
            icap_busy = b;
        end
        tick();
        c++;
        icap_busy = 1'b0;
        chk("sv_valid", 32'(stat_valid), 32'd1);
        chk("sv_data",  32'(stat_data), 32'(exp_data));
        chk("sv_err",   32'(stat_err), 32'(exp_err));
        chk("sv_busy",  32'(busy), 32'd0);
        chk("sv_ce",    32'(icap_ce_n), 32'd1);
        if (stat_valid) valid_c = c;
        stat_req = 1'b0;
        tick();
        chk("sv_valid1", 32'(stat_valid), 32'd0);
        chk("sv_busy1",  32'(busy), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int ack_c, vc;
        rst_n     = 1'b0;
        boot_req  = 1'b0;
        stat_req  = 1'b0;
        boot_addr = 24'h0;
        icap_dout = 16'h0;
        icap_busy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_reset_outputs("init");
        end
        rst_n = 1'b1;
        tick();

        // Directed warm boot, no stalls
        run_boot(24'h080000, 1'b0, -1, 0, 1'b0, 99, ack_c);
        chk("ack_cycle", 32'(ack_c), 32'd15);
        do_reset();

        // Stall of 3 cycles on word 5
        run_boot(24'h080000, 1'b0, 5, 3, 1'b0, 99, ack_c);
        chk("ack_cycle_stall", 32'(ack_c), 32'd18);
        do_reset();

        // Simultaneous requests: boot wins, stat not serviced
        run_boot(24'($urandom()), 1'b0, -1, 0, 1'b1, 99, ack_c);
        chk("ack_cycle_prio", 32'(ack_c), 32'd15);
        do_reset();

        // Directed STAT read
        run_stat(16'h3CEC, 0, vc);
        chk("stat_cycle", 32'(vc), 32'd15);

        // Read timeout with ICAP busy stuck
        run_stat(16'($urandom()), 2, vc);
        chk("stat_tmo_cycle", 32'(vc), 32'(15 + RD_TMO - 1));

        // Random STAT reads with random stalls
        for (int i = 0; i < 4; i++) run_stat(16'($urandom()), 1, vc);

        // Reset during word 9: aborts, then waits for a fresh grant
        run_boot(24'($urandom()), 1'b0, -1, 0, 1'b0, 9, ack_c);
        chk("abort_noack", 32'(ack_c), 32'hFFFF_FFFF);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("post_rst_busy", 32'(busy), 32'd0);
            chk("post_rst_ce",   32'(icap_ce_n), 32'd1);
            chk("post_rst_ack",  32'(boot_ack), 32'd0);
        end
        run_stat(16'($urandom()), 1, vc);

        // Random boots with random stalls and early request drop
        for (int i = 0; i < 3; i++) begin
            run_boot(24'($urandom()), 1'b1, -1, 0, 1'b0, 99, ack_c);
            do_reset();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
